pwm_servo_array: RTL
====================

Name: pwm_servo_array

Overview:
- Parametrised multi-channel servo PWM generator: N channels, each emitting a (MIN_TICKS + setpoint)-tick pulse once per frame.
- Runs from the single system clock with an internal tick prescaler.
- Adds pause-to-neutral, a command watchdog failsafe, and per-frame slew limiting.
- Sits behind the motor peripheral bus decoder, which drives the setpoint write port.

Parameters:
- CHANNELS, 4, number of PWM outputs (1-16)
- WIDTH, 8, setpoint width in bits; NEUTRAL = 2^(WIDTH-1)-1 (127 at WIDTH=8)
- CLK_DIV, 47, clk_12MHz cycles per tick (default ≈255 kHz tick)
- PERIOD_TICKS, 5100, ticks per frame (20 ms at default)
- MIN_TICKS, 255, pulse length for setpoint 0 (1 ms at default); must be ≥1, and MIN_TICKS + 2^WIDTH - 1 < PERIOD_TICKS
- SLEW_STEP, 0, max change of active value per frame; 0 = unlimited
- WATCHDOG_FRAMES, 50, frames without a valid write before failsafe; 0 = disabled

Ports:
- clk_12MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  setpoint write strobe, one cycle per write
- wr_chan  in  8  target channel index
- wr_data  in  WIDTH  setpoint value
- pause  in  1  level; while high, all channels head to NEUTRAL
- pwm  out  CHANNELS  servo pulse outputs, registered
- frame_start  out  1  one-cycle pulse on the tick where the frame counter is 0
- failsafe  out  1  high while the watchdog has expired
- rd_chan  in  8  readback channel index
- rd_data  out  WIDTH  active value of rd_chan, combinational; 0 if rd_chan ≥ CHANNELS

Behaviour:
- Reset (asynchronous, active-high) forces:
  - prescaler = 0, frame_cnt = 0, watchdog count = 0
  - pwm = 0, frame_start = 0, failsafe = 0
  - setpoint[i] = NEUTRAL, active[i] = NEUTRAL
- Reset mid-pulse drops pwm immediately, with no glitch back high.
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps.
  - tick is high for the single cycle where prescaler == CLK_DIV-1.
  - The first tick occurs CLK_DIV cycles after reset deasserts.
- Frame counter: advances on tick, 0..PERIOD_TICKS-1, then wraps to 0.
- Tick with frame_cnt == 0 (frame boundary):
  - frame_start = 1 for that cycle.
  - target[i] = NEUTRAL if (pause | failsafe), else setpoint[i].
  - SLEW_STEP = 0: active[i] <= target[i].
  - Otherwise active[i] moves toward target[i] by min(SLEW_STEP, |target-active|); no overshoot, no wrap.
  - pwm[i] <= 1 for all i.
- Other ticks: pwm[i] <= (frame_cnt < MIN_TICKS + active[i]), compared at WIDTH+log2(PERIOD_TICKS) bits with no truncation.
- Resulting pulse length: high for exactly (MIN_TICKS + active) ticks, i.e. (MIN_TICKS + active)·CLK_DIV clocks.
- All channels rise on the same cycle.
- Setpoint writes:
  - wr_en with wr_chan < CHANNELS: setpoint[wr_chan] <= wr_data and the watchdog count clears.
  - wr_chan ≥ CHANNELS: write ignored, watchdog not cleared.
- Writes never affect the current frame's pulse. A write on the same cycle as the frame-boundary tick is not latched; it takes effect at the next frame.
- Watchdog:
  - Counts frame boundaries since the last valid write, saturating at WATCHDOG_FRAMES.
  - Count reaching WATCHDOG_FRAMES sets failsafe = 1.
  - Any valid write clears failsafe the next cycle.
  - Stored setpoints are kept, so recovery resumes from the last commanded values (subject to slew).
  - Disabled and failsafe held 0 when WATCHDOG_FRAMES = 0.
- pause:
  - Sampled only at the frame boundary.
  - Does not alter setpoints.
  - Deasserting it resumes the setpoints at the next frame.
- Out-of-range parameter combinations are a compile-time error.

Test Plan:
- Reset, then defaults with CLK_DIV = 4: every channel pulses high for (255+127)·4 = 1528 clocks every 5100·4 = 20400 clocks; frame_start fires once per 20400 clocks.
- Write ch0 = 0, ch1 = 255: the next frame after the write gives ch0 a 255-tick pulse and ch1 a 510-tick pulse; the in-progress frame is unchanged; a write on the boundary-tick cycle is delayed one frame.
- SLEW_STEP = 10, ch2 written from 127 to 200: active reads 137, 147, … 197, 200 on successive frames, then holds at 200 with no overshoot.
- WATCHDOG_FRAMES = 3, one write ch0 = 40 then silence: failsafe rises at the 3rd frame boundary, the next frame shows 382-tick pulses, and a write to ch1 restores ch0 = 40 and clears failsafe.
- pause high for 2 frames with ch0 = 250: 382-tick pulses in those frames, 505-tick pulses after deassert; a write with wr_chan = CHANNELS is ignored and does not feed the watchdog.
- Assert reset while pwm is high mid-frame: pwm falls asynchronously; after release, outputs and counters restart as in the first scenario.

Source files
------------

// File: rtl/pwm_servo_array_if.sv
// Setpoint write port and active-value readback between the motor bus decoder and the servo PWM block.
interface pwm_servo_array_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [7:0]       wr_chan;
    logic [WIDTH-1:0] wr_data;
    logic [7:0]       rd_chan;
    logic [WIDTH-1:0] rd_data;

    modport master (output wr_en, wr_chan, wr_data, rd_chan, input rd_data);
    modport slave  (input wr_en, wr_chan, wr_data, rd_chan, output rd_data);
endinterface

// File: rtl/pwm_servo_array.sv
// Multi-channel servo PWM: shared prescaler/frame timing, per-channel setpoint, slew-limited
// active value and registered pulse, plus pause-to-neutral and a command watchdog failsafe.
module pwm_servo_lane #(
    parameter int WIDTH     = 8,
    parameter int MIN_TICKS = 255,
    parameter int SLEW_STEP = 0,
    parameter int FCW       = 13
) (
    input  logic             clk_12MHz,
    input  logic             reset,
    input  logic             tick,
    input  logic             boundary,
    input  logic             to_neutral,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [FCW-1:0]   frame_cnt,
    output logic             pwm,
    output logic [WIDTH-1:0] active
);
    localparam logic [WIDTH-1:0] NEUTRAL = WIDTH'((1 << (WIDTH - 1)) - 1);
    // A step at least as large as the value range can never bind, so treat it as unlimited.
    localparam int               STEP_C  = (SLEW_STEP >= (1 << WIDTH)) ? 0 : SLEW_STEP;
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(STEP_C);
    localparam int               CW      = WIDTH + FCW + 1;

    logic [WIDTH-1:0] setpoint, target, next_active;
    logic             pulse_on;

    always_comb begin
        target      = to_neutral ? NEUTRAL : setpoint;
        next_active = target;
        if (STEP_C != 0) begin
            if (target > active && (target - active) > STEP)
                next_active = active + STEP;
            else if (active > target && (active - target) > STEP)
                next_active = active - STEP;
        end
        pulse_on = CW'(frame_cnt) < (CW'(MIN_TICKS) + CW'(active));
    end

    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            setpoint <= NEUTRAL;
            active   <= NEUTRAL;
            pwm      <= 1'b0;
        end else begin
            // Boundary samples the old setpoint, so a write on that cycle lands a frame later.
            if (wr_hit)
                setpoint <= wr_data;
            if (boundary) begin
                active <= next_active;
                pwm    <= 1'b1;
            end else if (tick) begin
                pwm <= pulse_on;
            end
        end
    end
endmodule

module pwm_servo_array #(
    parameter int CHANNELS        = 4,
    parameter int WIDTH           = 8,
    parameter int CLK_DIV         = 47,
    parameter int PERIOD_TICKS    = 5100,
    parameter int MIN_TICKS       = 255,
    parameter int SLEW_STEP       = 0,
    parameter int WATCHDOG_FRAMES = 50
) (
    input  logic                clk_12MHz,
    input  logic                reset,
    input  logic                pause,
    pwm_servo_array_if.slave    bus,
    output logic [CHANNELS-1:0] pwm,
    output logic                frame_start,
    output logic                failsafe
);
    localparam int FCW = $clog2(PERIOD_TICKS);
    localparam int PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WDW = $clog2(WATCHDOG_FRAMES + 2);
    localparam logic [WDW-1:0] WD_MAX = WDW'(WATCHDOG_FRAMES);

    if (CHANNELS < 1 || CHANNELS > 16 || WIDTH < 1 || WIDTH > 16 || CLK_DIV < 1 ||
        MIN_TICKS < 1 || MIN_TICKS + (1 << WIDTH) - 1 >= PERIOD_TICKS ||
        SLEW_STEP < 0 || WATCHDOG_FRAMES < 0) begin : g_param_err
        $error("pwm_servo_array: illegal parameter combination");
    end

    logic [PSW-1:0]                  prescaler;
    logic [FCW-1:0]                  frame_cnt;
    logic [WDW-1:0]                  wd_cnt, wd_cnt_next;
    logic                            tick, boundary, wr_valid, to_neutral;
    logic [CHANNELS-1:0][WIDTH-1:0]  active;

    assign tick        = (prescaler == PSW'(CLK_DIV - 1));
    assign boundary    = tick && (frame_cnt == '0);
    assign wr_valid    = bus.wr_en && (bus.wr_chan < 8'(CHANNELS));
    assign to_neutral  = pause | failsafe;
    assign wd_cnt_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            prescaler   <= tick ? '0 : prescaler + 1'b1;
            frame_start <= boundary;
            if (tick)
                frame_cnt <= (frame_cnt == FCW'(PERIOD_TICKS - 1)) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Watchdog counts frame boundaries since the last in-range write; a write wins over a boundary.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            wd_cnt   <= '0;
            failsafe <= 1'b0;
        end else if (wr_valid) begin
            wd_cnt   <= '0;
            failsafe <= 1'b0;
        end else if (boundary && WATCHDOG_FRAMES != 0) begin
            wd_cnt   <= wd_cnt_next;
            failsafe <= (wd_cnt_next == WD_MAX);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pwm_servo_lane #(
            .WIDTH(WIDTH), .MIN_TICKS(MIN_TICKS), .SLEW_STEP(SLEW_STEP), .FCW(FCW)
        ) u_lane (
            .clk_12MHz (clk_12MHz),
            .reset     (reset),
            .tick      (tick),
            .boundary  (boundary),
            .to_neutral(to_neutral),
            .wr_hit    (bus.wr_en && bus.wr_chan == 8'(g)),
            .wr_data   (bus.wr_data),
            .frame_cnt (frame_cnt),
            .pwm       (pwm[g]),
            .active    (active[g])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.rd_chan == 8'(i))
                bus.rd_data = active[i];
    end
endmodule
